// File: rtl/axi_port_arb.sv
// Round-robin arbiter that shares one AXI transaction controller between N requesters.
// Optional busy watchdog compiled in with `define AXI_ARB_WDOG_EN.
module axi_port_arb #(
  parameter int N_PORTS = 3,
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_PORTS-1:0]          req_i,
  input  logic [N_PORTS-1:0]          rw_i,
  input  logic [N_PORTS*ADDR_W-1:0]   addr_i,
  input  logic [N_PORTS*DATA_W-1:0]   wdata_i,
  input  logic [N_PORTS*8-1:0]        len_i,
  output logic [N_PORTS-1:0]          gnt_o,
  output logic [N_PORTS-1:0]          done_o,
  output logic                        err_o,
  input  logic                        ds_ready_i,
  output logic                        ds_req_o,
  output logic                        ds_rw_o,
  output logic [ADDR_W-1:0]           ds_addr_o,
  output logic [DATA_W-1:0]           ds_wdata_o,
  output logic [7:0]                  ds_len_o,
  input  logic                        ds_done_i,
  output logic                        busy_o
);

  localparam int PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_BUSY    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t              r_state;
  logic [PTR_W-1:0]    r_rr_ptr;
  logic [N_PORTS-1:0]  r_gnt;
  logic [N_PORTS-1:0]  r_done;
  logic                r_err;
  logic                r_ds_req;
  logic                r_ds_rw;
  logic [ADDR_W-1:0]   r_ds_addr;
  logic [DATA_W-1:0]   r_ds_wdata;
  logic [7:0]          r_ds_len;
  logic                r_busy;

  logic                w_found;
  logic                w_hit;
  logic [PTR_W-1:0]    w_win;
  logic [PTR_W-1:0]    w_sel;
  logic [PTR_W-1:0]    w_next_ptr;
  logic [N_PORTS-1:0]  w_onehot;
  logic                w_owner_req;
  int unsigned         w_idx;

`ifdef AXI_ARB_WDOG_EN
  logic [31:0]         r_wdog_cnt;
`else
  logic                w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT;
`endif

  // Rotating-priority search: first requester at or after r_rr_ptr, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_hit   = 1'b0;
    w_win   = '0;
    w_sel   = '0;
    w_idx   = 32'd0;
    for (int i = 0; i < N_PORTS; i++) begin
      w_idx   = (32'(r_rr_ptr) + 32'(i)) % 32'(N_PORTS);
      w_sel   = PTR_W'(w_idx);
      w_hit   = !w_found && req_i[w_sel];
      w_win   = w_hit ? w_sel : w_win;
      w_found = w_found | w_hit;
    end
  end

  assign w_next_ptr  = (w_win == PTR_W'(N_PORTS - 1)) ? '0 : (w_win + PTR_W'(1));
  assign w_onehot    = {{(N_PORTS-1){1'b0}}, 1'b1} << w_win;
  assign w_owner_req = |(r_gnt & req_i);

  // Arbitration / sequencing FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= '0;
      r_gnt      <= '0;
      r_done     <= '0;
      r_err      <= 1'b0;
      r_ds_req   <= 1'b0;
      r_ds_rw    <= 1'b0;
      r_ds_addr  <= '0;
      r_ds_wdata <= '0;
      r_ds_len   <= 8'd0;
      r_busy     <= 1'b0;
`ifdef AXI_ARB_WDOG_EN
      r_wdog_cnt <= 32'd0;
`endif
    end else begin
      r_done   <= '0;
      r_err    <= 1'b0;
      r_ds_req <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ds_ready_i && w_found) begin
            r_gnt      <= w_onehot;
            r_ds_rw    <= rw_i[w_win];
            r_ds_addr  <= addr_i[32'(w_win)*ADDR_W +: ADDR_W];
            r_ds_wdata <= wdata_i[32'(w_win)*DATA_W +: DATA_W];
            r_ds_len   <= len_i[32'(w_win)*8 +: 8];
            r_rr_ptr   <= w_next_ptr;
            r_busy     <= 1'b1;
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_ds_req <= 1'b1;
          r_state  <= S_BUSY;
`ifdef AXI_ARB_WDOG_EN
          r_wdog_cnt <= 32'd0;
`endif
        end
        S_BUSY: begin
          // A completion seen while the request pulse is still out is a leftover, not ours.
          if (ds_done_i && !r_ds_req) begin
            r_done  <= r_gnt;
            r_state <= S_RELEASE;
`ifdef AXI_ARB_WDOG_EN
          end else if (r_wdog_cnt == 32'(TIMEOUT - 1)) begin
            r_done  <= r_gnt;
            r_err   <= 1'b1;
            r_state <= S_RELEASE;
          end else begin
            r_wdog_cnt <= r_wdog_cnt + 32'd1;
`endif
          end
        end
        S_RELEASE: begin
          if (!w_owner_req) begin
            r_gnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_gnt   <= '0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt_o      = r_gnt;
  assign done_o     = r_done;
  assign err_o      = r_err;
  assign ds_req_o   = r_ds_req;
  assign ds_rw_o    = r_ds_rw;
  assign ds_addr_o  = r_ds_addr;
  assign ds_wdata_o = r_ds_wdata;
  assign ds_len_o   = r_ds_len;
  assign busy_o     = r_busy;

endmodule

// File: tb/tb_axi_port_arb.sv
// Directed bench for axi_port_arb; issued commands are checked against a scoreboard queue.
module tb_axi_port_arb;

  localparam int NP = 3;
  localparam int AW = 64;
  localparam int DW = 64;

  logic              clk;
  logic              rst;
  logic [NP-1:0]     req_i;
  logic [NP-1:0]     rw_i;
  logic [NP*AW-1:0]  addr_i;
  logic [NP*DW-1:0]  wdata_i;
  logic [NP*8-1:0]   len_i;
  logic [NP-1:0]     gnt_o;
  logic [NP-1:0]     done_o;
  logic              err_o;
  logic              ds_ready_i;
  logic              ds_req_o;
  logic              ds_rw_o;
  logic [AW-1:0]     ds_addr_o;
  logic [DW-1:0]     ds_wdata_o;
  logic [7:0]        ds_len_o;
  logic              ds_done_i;
  logic              busy_o;

  typedef struct {
    int          port;
    logic        rw;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  len;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_req = 0;
  int   req_mark;

  axi_port_arb #(.N_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .rw_i(rw_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .len_i(len_i), .gnt_o(gnt_o), .done_o(done_o),
    .err_o(err_o), .ds_ready_i(ds_ready_i), .ds_req_o(ds_req_o),
    .ds_rw_o(ds_rw_o), .ds_addr_o(ds_addr_o), .ds_wdata_o(ds_wdata_o),
    .ds_len_o(ds_len_o), .ds_done_i(ds_done_i), .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    exp_t e;
    logic [NP-1:0] oh;
    @(posedge clk);
    #1;
    if (ds_req_o === 1'b1) begin
      n_req++;
      chk("sb_has_entry", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e  = sb.pop_front();
        oh = 3'b001 << e.port;
        chk("issue_gnt",   64'(gnt_o),    64'(oh));
        chk("issue_rw",    64'(ds_rw_o),  64'(e.rw));
        chk("issue_addr",  ds_addr_o,     e.addr);
        chk("issue_wdata", ds_wdata_o,    e.wdata);
        chk("issue_len",   64'(ds_len_o), 64'(e.len));
      end
    end
  endtask

  task automatic raise(input int k, input logic rw, input logic [63:0] a,
                       input logic [63:0] d, input logic [7:0] l);
    exp_t e;
    rw_i[k]             = rw;
    addr_i[k*AW +: AW]  = a;
    wdata_i[k*DW +: DW] = d;
    len_i[k*8 +: 8]     = l;
    req_i[k]            = 1'b1;
    e.port = k; e.rw = rw; e.addr = a; e.wdata = d; e.len = l;
    sb.push_back(e);
  endtask

  task automatic wait_gnt(input string tag, input logic [NP-1:0] exp);
    int k = 0;
    while (gnt_o == '0 && k < 20) begin
      tick();
      k++;
    end
    chk(tag, 64'(gnt_o), 64'(exp));
  endtask

  // Issue pulse, then completion after dly cycles, checking the done pulse.
  task automatic finish_txn(input int p, input int dly);
    logic [NP-1:0] oh;
    oh = 3'b001 << p;
    tick();
    repeat (dly - 1) tick();
    ds_done_i = 1'b1;
    tick();
    chk("done_pulse", 64'(done_o), 64'(oh));
    ds_done_i = 1'b0;
  endtask

  initial begin
    rst = 1'b0; req_i = '0; rw_i = '0; addr_i = '0; wdata_i = '0; len_i = '0;
    ds_ready_i = 1'b1; ds_done_i = 1'b0;
    tick(); tick();
    chk("rst_gnt",  64'(gnt_o),  64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_req",  64'(ds_req_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_err",  64'(err_o),  64'd0);
    chk("rst_addr", ds_addr_o,   64'd0);
    rst = 1'b1;
    tick();

    // Fairness with all three requesting continuously.
    req_mark = n_req;
    raise(0, 1'b0, 64'h0000_0000_0000_1000, 64'h0, 8'd3);
    raise(1, 1'b1, 64'h0000_0000_0000_2000, 64'hDEAD_BEEF_0000_0001, 8'd0);
    raise(2, 1'b0, 64'h0000_0000_0000_3000, 64'h0, 8'd15);
    for (int r = 0; r < 2; r++) begin
      for (int p = 0; p < NP; p++) begin
        wait_gnt("rr_gnt", 3'b001 << p);
        finish_txn(p, 3);
        tick();
        chk("rr_gnt_hold", 64'(gnt_o), 64'(3'b001 << p));
        req_i[p] = 1'b0;
        tick();
        chk("rr_gnt_clear", 64'(gnt_o), 64'd0);
        if (r == 0)
          raise(p, p[0], 64'h0000_0001_0000_0000 + 64'(p * 64),
                64'hCAFE_0000_0000_0000 + 64'(p), 8'(p + 1));
      end
    end
    chk("rr_req_count", 64'(n_req - req_mark), 64'd6);

    // Stale request: owner keeps req high after done.
    raise(0, 1'b1, 64'h0000_0000_0000_4000, 64'h1111_2222_3333_4444, 8'd1);
    raise(2, 1'b0, 64'h0000_0000_0000_5000, 64'h0, 8'd2);
    wait_gnt("stale_gnt0", 3'b001);
    finish_txn(0, 3);
    req_mark = n_req;
    repeat (4) begin
      tick();
      chk("stale_hold", 64'(gnt_o), 64'h1);
    end
    chk("stale_no_req", 64'(n_req - req_mark), 64'd0);
    req_i[0] = 1'b0;
    tick();
    chk("stale_clear", 64'(gnt_o), 64'd0);
    tick();
    chk("stale_gnt2", 64'(gnt_o), 64'h4);
    finish_txn(2, 3);
    req_i[2] = 1'b0;
    tick();
    chk("stale_idle", 64'(gnt_o), 64'd0);

    // Downstream not ready holds off arbitration; then async reset mid-BUSY.
    ds_ready_i = 1'b0;
    raise(0, 1'b0, 64'h0000_0000_0000_6000, 64'h0, 8'd4);
    req_i = 3'b111;
    req_mark = n_req;
    repeat (10) begin
      tick();
      chk("nrdy_gnt", 64'(gnt_o), 64'd0);
    end
    chk("nrdy_no_req", 64'(n_req - req_mark), 64'd0);
    ds_ready_i = 1'b1;
    tick();
    chk("rdy_gnt", 64'(gnt_o), 64'h1);
    tick();
    tick();
    chk("pre_rst_busy", 64'(busy_o), 64'd1);
    #3 rst = 1'b0;
    #1;
    chk("arst_gnt",  64'(gnt_o),  64'd0);
    chk("arst_busy", 64'(busy_o), 64'd0);
    chk("arst_done", 64'(done_o), 64'd0);
    chk("arst_req",  64'(ds_req_o), 64'd0);
    chk("arst_addr", ds_addr_o,   64'd0);
    #2 rst = 1'b1;
    raise(0, 1'b1, 64'h0000_0000_0000_7000, 64'h5555_AAAA_5555_AAAA, 8'd9);
    tick();
    chk("post_rst_gnt", 64'(gnt_o), 64'h1);
    finish_txn(0, 4);
    req_i = '0;
    tick();
    chk("post_rst_idle", 64'(gnt_o), 64'd0);

    // Single read from port 1.
    req_mark = n_req;
    raise(1, 1'b0, 64'h0000_0000_8000_0040, 64'h0, 8'd7);
    tick();
    chk("t1_gnt", 64'(gnt_o), 64'h2);
    chk("t1_no_req_yet", 64'(ds_req_o), 64'd0);
    tick();
    chk("t1_req_count", 64'(n_req - req_mark), 64'd1);
    chk("t1_busy", 64'(busy_o), 64'd1);
    tick();
    chk("t1_req_pulse_end", 64'(ds_req_o), 64'd0);
    repeat (3) tick();
    chk("t1_err", 64'(err_o), 64'd0);
    ds_done_i = 1'b1;
    tick();
    chk("t1_done", 64'(done_o), 64'h2);
    ds_done_i = 1'b0;
    req_i[1] = 1'b0;
    tick();
    chk("t1_done_end", 64'(done_o), 64'd0);
    chk("t1_gnt_clear", 64'(gnt_o), 64'd0);
    chk("t1_idle", 64'(busy_o), 64'd0);

`ifdef AXI_ARB_WDOG_EN
    // Watchdog: no completion ever arrives.
    raise(1, 1'b1, 64'h0000_0000_0000_9000, 64'h0123_4567_89AB_CDEF, 8'd0);
    wait_gnt("wd_gnt", 3'b010);
    tick();
    repeat (15) begin
      tick();
      chk("wd_err_early", 64'(err_o), 64'd0);
    end
    tick();
    chk("wd_err", 64'(err_o), 64'd1);
    chk("wd_done", 64'(done_o), 64'h2);
    req_i[1] = 1'b0;
    tick();
    chk("wd_err_end", 64'(err_o), 64'd0);
    chk("wd_gnt_clear", 64'(gnt_o), 64'd0);
    chk("wd_idle", 64'(busy_o), 64'd0);
`endif

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axi_port_arb.md
Name: axi_port_arb

Overview:
- Round-robin arbiter and sequencer that shares the single AXI transaction controller between N requesters (icache, dcache, mmio).
- Allows one outstanding transaction at a time.
- Latches the winner's command and issues it downstream as a one-cycle request pulse.
- Waits for completion, returns a done pulse to the winner, then re-arbitrates.

Parameters:
- N_PORTS, 3, number of requesters; port 0 = icache, 1 = dcache, 2 = mmio.
- ADDR_W, 64, address width.
- DATA_W, 64, single-beat write data width.
- TIMEOUT, 1024, watchdog limit in cycles (used only with AXI_ARB_WDOG_EN).

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-low reset
- req_i  input  N_PORTS  per-port request; held high until that port's done_o
- rw_i  input  N_PORTS  per-port direction (0 read, 1 write)
- addr_i  input  N_PORTS*ADDR_W  per-port address, packed, port k at [k*ADDR_W +: ADDR_W]
- wdata_i  input  N_PORTS*DATA_W  per-port write data, packed
- len_i  input  N_PORTS*8  per-port burst length (beats-1)
- gnt_o  output  N_PORTS  one-hot; current owner, held from grant to release
- done_o  output  N_PORTS  one-cycle completion pulse to the owner
- err_o  output  1  one-cycle timeout pulse (0 when the watchdog is compiled out)
- ds_ready_i  input  1  downstream controller idle and able to accept
- ds_req_o  output  1  one-cycle request pulse to the controller
- ds_rw_o  output  1  latched direction
- ds_addr_o  output  ADDR_W  latched address
- ds_wdata_o  output  DATA_W  latched write data
- ds_len_o  output  8  latched length
- ds_done_i  input  1  controller completion (level or pulse)
- busy_o  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; rr_ptr=0; gnt_o, done_o, ds_req_o, err_o, busy_o all 0; latched ds_* fields 0.
- IDLE:
  - When ds_ready_i=1 and |req_i, pick the first requesting port at or after rr_ptr, wrapping modulo N_PORTS.
  - Set gnt_o one-hot, latch rw/addr/wdata/len, set rr_ptr=(winner+1) mod N_PORTS, go to ISSUE.
  - If ds_ready_i=0, stay in IDLE and grant nothing, even when requests are pending.
- ISSUE: ds_req_o=1 for exactly this cycle; go to BUSY. Latency from request to ds_req_o is 2 cycles minimum.
- BUSY:
  - Wait for ds_done_i=1.
  - On ds_done_i: done_o[owner]=1 for one cycle, go to RELEASE.
  - ds_done_i seen in ISSUE is ignored; the controller never completes within one cycle.
- RELEASE:
  - Hold gnt_o until req_i[owner]=0, then clear gnt_o and go to IDLE.
  - This prevents re-granting a stale, still-high request.
  - If req_i[owner] is already 0 in the done cycle, RELEASE lasts one cycle.
- Stability: ds_* fields are stable from ISSUE through RELEASE; requester inputs may change freely after grant.
- Fairness: with all ports requesting continuously, grant order is 0,1,2,0,... A port waits at most N_PORTS-1 transactions.
- Simultaneous events:
  - A new request arriving during BUSY waits for IDLE.
  - A requester dropping req_i before done is not allowed; the block still completes the transaction and pulses done_o.
- Reset mid-transaction aborts immediately to IDLE with all outputs 0. The downstream controller is reset by the same rst.
- busy_o = (state != IDLE).

Optional Feature:
- Macro: AXI_ARB_WDOG_EN.
- With the macro defined:
  - A 32-bit counter clears on entry to BUSY and increments every BUSY cycle.
  - When it reaches TIMEOUT, pulse err_o and done_o[owner] together for one cycle, then go to RELEASE.
- Without the macro: no counter is built, err_o is tied to 0, and BUSY waits indefinitely.

Test Plan:
- Single request, port 1 read at addr 0x8000_0040, len 7, ds_ready=1:
  - gnt_o=3'b010 next cycle; ds_req_o pulse 2 cycles after req, with ds_addr_o=0x8000_0040 and ds_len_o=7.
  - ds_done_i 5 cycles later -> done_o=3'b010 one cycle.
- All three ports held high, done returned 3 cycles after each ds_req_o, each port dropping req_i the cycle after its done_o:
  - Grant sequence 0,1,2,0,1,2; exactly one ds_req_o per grant.
- Stale request: port 0 keeps req_i high 4 cycles after done_o, port 2 also requesting:
  - gnt_o stays 3'b001, no new ds_req_o, until port 0 drops; then port 2 granted.
- ds_ready_i=0 with req_i=3'b111 for 10 cycles -> no gnt_o, no ds_req_o; grant follows 1 cycle after ds_ready_i rises.
- Assert rst=0 during BUSY (asynchronous, between edges):
  - gnt_o, busy_o, done_o go to 0 immediately; after release, rr_ptr=0, so port 0 wins first.
- With AXI_ARB_WDOG_EN and TIMEOUT=16, ds_done_i never asserted:
  - err_o and done_o[owner] pulse together exactly 16 cycles after entering BUSY; the block returns to IDLE once the owner drops its request.
